mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  reset, synchronous, active-high; clock clk.
REQ-003 SHALL: in_valid  input  1  EX/MEM slot holds an instruction.
REQ-004 SHALL: mem_read, mem_write, byte_op  input  1 each  load, store, and byte-size (LDRB/STRB) qualifiers.
REQ-005 SHALL: alu_result  input  32  ALU result; this is the memory address for memory operations.
REQ-006 SHALL: store_data  input  32  store source register value.
REQ-007 SHALL: rd_in  input  4; link_in, wb_en_in  input  1 each  writeback tags.
REQ-008 SHALL: dmem_req, dmem_we  output  1; dmem_addr  output  32; dmem_wdata  output  32; dmem_wstrb  output  4  data memory request port.
REQ-009 SHALL: dmem_ack  input  1; dmem_rdata  input  32  memory response.
REQ-010 SHALL: mem_out  output  32; rd_out  output  4; link_out, wb_en_out, fault_out  output  1 each  feed to the MEM/WB register.
REQ-011 SHALL: stall_out  output  1  freezes IF through EX/MEM while high.

Function
REQ-012 SHALL: implement states IDLE, REQ and RESP.
REQ-013 SHALL: in IDLE with a non-memory op, pass alu_result/rd_in/link_in/wb_en_in to the outputs combinationally, with stall_out=0 and zero added latency.
REQ-014 SHALL: in IDLE with in_valid and (mem_read|mem_write), latch all inputs, assert stall_out, force wb_en_out=0 (bubble), and move to REQ.
REQ-015 SHALL: in REQ, hold dmem_req=1 with the request fields stable from the latched values until the cycle dmem_ack=1.
REQ-016 SHALL: on ack, capture the load result and move to RESP; stall_out stays 1 through the ack cycle.
REQ-017 SHALL: in RESP, present the latched tags and captured data for exactly one cycle with stall_out=0, then return to IDLE.
REQ-018 SHALL: have a minimum memory-op occupancy of 3 cycles (IDLE detect, REQ with same-cycle ack, RESP).
REQ-019 SHALL: drive dmem_addr = {addr[31:2],2'b00} for all accesses.
REQ-020 SHALL: for word accesses, use wstrb=4'b1111 and pass data unmodified; addr[1:0] is ignored.
REQ-021 SHALL: for a byte store, use wdata = store_data[7:0] replicated to all four lanes and wstrb = 4'b0001 << addr[1:0].
REQ-022 SHALL: for a byte load, set mem_out = zero-extended rdata lane addr[1:0], little-endian.
REQ-023 SHALL: for stores, set mem_out = 0 and wb_en_out = latched wb_en_in.
REQ-024 SHALL: ignore dmem_ack outside REQ.
REQ-025 SHALL: when in_valid=0, drive wb_en_out=0 and stall_out=0.

Reset
REQ-026 SHALL: on reset, set state=IDLE, all latched registers=0, dmem_req=0, stall_out=0, fault_out=0 and wb_en_out=0.
REQ-027 SHALL: on reset mid-REQ, drop dmem_req in the next cycle and discard any later ack.

Configuration
REQ-028 SHALL: with DMEM_TIMEOUT_EN defined, count REQ cycles in an 8-bit counter.
REQ-029 SHALL: with DMEM_TIMEOUT_EN defined, when the count reaches DMEM_TIMEOUT_CYCLES=255 without ack, deassert dmem_req, enter RESP with fault_out=1 and wb_en_out=0.
REQ-030 SHALL: with DMEM_TIMEOUT_EN defined, give ack priority if ack arrives in the same cycle as the timeout.
REQ-031 SHALL: without DMEM_TIMEOUT_EN, wait in REQ indefinitely and tie fault_out to 0.

Structure
REQ-032 SHALL: place the state enum, DMEM_TIMEOUT_CYCLES and the width constants (REG_ADDR_W=4, DATA_W=32) in shared package arm_pipe_pkg.
REQ-033 SHALL: use one sub-module, dmem_lane_align, containing the combinational byte-lane steering for the store strobe/data and the load extraction.

Verification
REQ-034 SHALL: cover ADD result 0x1234, no memory op -> same-cycle mem_out=0x1234, wb_en_out=1, stall_out=0.
REQ-035 SHALL: cover LDR addr 0x100, ack after 2 cycles with rdata 0xDEADBEEF -> stall_out high 3 cycles, then RESP with mem_out=0xDEADBEEF and rd_out tag preserved.
REQ-036 SHALL: cover LDRB addr 0x103, rdata 0xAABBCCDD -> dmem_addr=0x100, mem_out=0x000000AA.
REQ-037 SHALL: cover STRB addr 0x202, store_data 0x55 -> dmem_wstrb=0100, dmem_wdata=0x55555555, dmem_we=1.
REQ-038 SHALL: cover reset asserted in REQ, then ack one cycle later -> dmem_req=0, state IDLE, no output change, ack ignored.
REQ-039 SHALL: cover, with DMEM_TIMEOUT_EN, no ack for 255 cycles -> fault_out=1 for one cycle, wb_en_out=0, stall released.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared types and sizing constants for the ARM-style pipeline memory stage.
package arm_pipe_pkg;

  localparam int unsigned REG_ADDR_W          = 4;
  localparam int unsigned DATA_W              = 32;
  localparam int unsigned STRB_W              = DATA_W / 8;
  localparam int unsigned DMEM_TIMEOUT_CYCLES = 255;
  localparam int unsigned TO_CNT_W            = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // Memory instruction captured from EX/MEM when the access starts
  typedef struct packed {
    logic                  wr;
    logic                  byte_op;
    logic [DATA_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [REG_ADDR_W-1:0] rd_tag;
    logic                  link;
    logic                  wb_en;
  } mem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store data/strobe generation and little-endian load extraction.
module dmem_lane_align
  import arm_pipe_pkg::*;
(
  input  logic              i_byte_op,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic [DATA_W-1:0] i_load_data,
  output logic [DATA_W-1:0] o_wdata,
  output logic [STRB_W-1:0] o_wstrb,
  output logic [DATA_W-1:0] o_load_data
);

  always_comb begin
    o_wdata     = i_store_data;
    o_wstrb     = '1;
    o_load_data = i_load_data;
    if (i_byte_op) begin
      o_wdata     = {STRB_W{i_store_data[7:0]}};
      o_wstrb     = STRB_W'(1) << i_addr_lo;
      o_load_data = DATA_W'(i_load_data[{i_addr_lo, 3'b000} +: 8]);
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: passes ALU ops through, sequences loads/stores as IDLE->REQ->RESP while stalling.
// Optional: define DMEM_TIMEOUT_EN to abort a request with fault_out after DMEM_TIMEOUT_CYCLES.
module mem_access_stage
  import arm_pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  byte_op,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  link_in,
  input  logic                  wb_en_in,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  output logic [STRB_W-1:0]     dmem_wstrb,
  input  logic                  dmem_ack,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic [DATA_W-1:0]     mem_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  link_out,
  output logic                  wb_en_out,
  output logic                  fault_out,
  output logic                  stall_out
);

  mem_state_e        r_state;
  mem_state_e        w_next_state;
  mem_req_t          r_req;
  logic [DATA_W-1:0] r_rdata;
  logic              w_mem_op;
  logic              w_accept;
  logic              w_ack;
  logic              w_timeout;
  logic              w_fault;
  logic [DATA_W-1:0] w_wdata;
  logic [STRB_W-1:0] w_wstrb;
  logic [DATA_W-1:0] w_load_data;

  assign w_mem_op = in_valid & (mem_read | mem_write);
  assign w_accept = (r_state == IDLE) & w_mem_op;
  assign w_ack    = (r_state == REQ) & dmem_ack;

`ifdef DMEM_TIMEOUT_EN
  logic [TO_CNT_W-1:0] r_to_cnt;
  logic                r_fault;

  // Counts completed REQ cycles; the 255th cycle without ack is the timeout
  always_ff @(posedge clk) begin
    if (reset || (r_state != REQ)) r_to_cnt <= '0;
    else                           r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
  end

  assign w_timeout = (r_state == REQ) & ~dmem_ack &
                     (r_to_cnt == TO_CNT_W'(DMEM_TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset)                r_fault <= 1'b0;
    else if (w_timeout)       r_fault <= 1'b1;
    else if (r_state == RESP) r_fault <= 1'b0;
  end

  assign w_fault = r_fault;
`else
  assign w_timeout = 1'b0;
  assign w_fault   = 1'b0;
`endif

  dmem_lane_align u_lane_align (
    .i_byte_op    (r_req.byte_op),
    .i_addr_lo    (r_req.addr[1:0]),
    .i_store_data (r_req.wdata),
    .i_load_data  (dmem_rdata),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb),
    .o_load_data  (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Request capture at access start and load data capture on ack
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_req.wr      <= mem_write;
        r_req.byte_op <= byte_op;
        r_req.addr    <= alu_result;
        r_req.wdata   <= store_data;
        r_req.rd_tag  <= rd_in;
        r_req.link    <= link_in;
        r_req.wb_en   <= wb_en_in;
      end
      if (w_ack) r_rdata <= w_load_data;
    end
  end

  always_comb begin
    w_next_state = r_state;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = {r_req.addr[DATA_W-1:2], 2'b00};
    dmem_wdata   = w_wdata;
    dmem_wstrb   = w_wstrb;
    mem_out      = alu_result;
    rd_out       = rd_in;
    link_out     = link_in;
    wb_en_out    = 1'b0;
    fault_out    = 1'b0;
    stall_out    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          stall_out    = 1'b1;
          w_next_state = REQ;
        end else begin
          wb_en_out = in_valid & wb_en_in;
        end
      end
      REQ: begin
        dmem_req  = 1'b1;
        dmem_we   = r_req.wr;
        stall_out = 1'b1;
        mem_out   = '0;
        rd_out    = r_req.rd_tag;
        link_out  = r_req.link;
        if (dmem_ack || w_timeout) w_next_state = RESP;
      end
      RESP: begin
        mem_out      = (r_req.wr | w_fault) ? '0 : r_rdata;
        rd_out       = r_req.rd_tag;
        link_out     = r_req.link;
        wb_en_out    = r_req.wb_en & ~w_fault;
        fault_out    = w_fault;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: randomized ALU/load/store stream against a reference model.
module tb_mem_access_stage;

  logic        clk, reset, in_valid, mem_read, mem_write, byte_op;
  logic [31:0] alu_result, store_data;
  logic [3:0]  rd_in;
  logic        link_in, wb_en_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_out;
  logic [3:0]  rd_out;
  logic        link_out, wb_en_out, fault_out, stall_out;

  typedef struct {
    logic        chk_data;
    logic [31:0] mem_out;
    logic [3:0]  rd;
    logic        link;
    logic        wb_en;
    logic        fault;
  } exp_out_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic        chk_w;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          delay;
  } exp_mem_t;

  exp_out_t out_q[$];
  exp_mem_t mem_q[$];

  int   n_checks = 0;
  int   n_pass   = 0;
  logic mon_en   = 1'b0;
  logic resp_en  = 1'b0;
  int   wait_cnt = 0;

  mem_access_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .byte_op    (byte_op),
    .alu_result (alu_result),
    .store_data (store_data),
    .rd_in      (rd_in),
    .link_in    (link_in),
    .wb_en_in   (wb_en_in),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .mem_out    (mem_out),
    .rd_out     (rd_out),
    .link_out   (link_out),
    .wb_en_out  (wb_en_out),
    .fault_out  (fault_out),
    .stall_out  (stall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Output monitor: every non-stalled cycle hands one record to MEM/WB
  initial begin : monitor
    exp_out_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !stall_out) begin
        if (out_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: actual wb_en_out=%0b mem_out=0x%08h required none at %0t",
                   wb_en_out, mem_out, $time);
        end else begin
          e = out_q.pop_front();
          check("wb_en_out", 32'(wb_en_out), 32'(e.wb_en));
          check("fault_out", 32'(fault_out), 32'(e.fault));
          if (e.chk_data) begin
            check("mem_out", mem_out, e.mem_out);
            check("rd_out", 32'(rd_out), 32'(e.rd));
            check("link_out", 32'(link_out), 32'(e.link));
          end
        end
      end
    end
  end

  // Memory responder: checks request fields every REQ cycle, acks after the chosen delay
  initial begin : responder
    exp_mem_t m;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        if (dmem_req) begin
          if (mem_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_dmem_req: actual addr 0x%08h required no request at %0t", dmem_addr, $time);
            dmem_ack = 1'b0;
          end else begin
            m = mem_q[0];
            check("dmem_addr", dmem_addr, m.addr);
            check("dmem_we", 32'(dmem_we), 32'(m.we));
            if (m.chk_w) begin
              check("dmem_wdata", dmem_wdata, m.wdata);
              check("dmem_wstrb", 32'(dmem_wstrb), 32'(m.wstrb));
            end
            if (wait_cnt == m.delay) begin
              dmem_ack   = 1'b1;
              dmem_rdata = m.rdata;
              void'(mem_q.pop_front());
              wait_cnt = 0;
            end else begin
              dmem_ack   = 1'b0;
              dmem_rdata = $urandom;
              wait_cnt++;
            end
          end
        end else begin
          dmem_ack   = ($urandom_range(0, 3) == 0);
          dmem_rdata = $urandom;
        end
      end
    end
  end

  // Drive one EX/MEM instruction, queue its expected results, hold it until consumed
  task automatic issue(input logic v, input logic rd, input logic wr, input logic bop,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [3:0] tag,
                       input logic lnk, input logic wbe, input logic [31:0] rdata,
                       input int delay, input logic tmo);
    exp_out_t e;
    exp_mem_t m;
    int       lane;
    int       exp_stall;
    int       st_cnt;
    logic     st;
    logic     done;
    in_valid   = v;
    mem_read   = rd;
    mem_write  = wr;
    byte_op    = bop;
    alu_result = alu;
    store_data = sd;
    rd_in      = tag;
    link_in    = lnk;
    wb_en_in   = wbe;
    lane       = int'(alu[1:0]);
    e.rd       = tag;
    e.link     = lnk;
    e.fault    = 1'b0;
    if (!(v && (rd || wr))) begin
      e.chk_data = v;
      e.mem_out  = alu;
      e.wb_en    = v & wbe;
      exp_stall  = 0;
    end else begin
      e.chk_data = 1'b1;
      e.wb_en    = wbe;
      if (wr)       e.mem_out = 32'h0;
      else if (bop) e.mem_out = (rdata >> (8 * lane)) & 32'hFF;
      else          e.mem_out = rdata;
      if (tmo) begin
        e.chk_data = 1'b0;
        e.wb_en    = 1'b0;
        e.fault    = 1'b1;
        exp_stall  = 1 + 255;
      end else begin
        exp_stall = 2 + delay;
        m.addr    = alu & ~32'h3;
        m.we      = wr;
        m.chk_w   = wr;
        m.wdata   = bop ? {4{sd[7:0]}} : sd;
        m.wstrb   = bop ? (4'b0001 << lane) : 4'b1111;
        m.rdata   = rdata;
        m.delay   = delay;
        mem_q.push_back(m);
      end
    end
    out_q.push_back(e);
    st_cnt = 0;
    done   = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      st = stall_out;
      @(posedge clk);
      #1;
      if (!st) begin
        done = 1'b1;
        break;
      end
      st_cnt++;
    end
    check("issue_completed", 32'(done), 32'd1);
    check("stall_cycles", 32'(st_cnt), 32'(exp_stall));
  endtask

  initial begin : main
    logic       v, rd, wr, bop;
    int         kind;
    reset      = 1'b1;
    in_valid   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    byte_op    = 1'b0;
    alu_result = 32'h0;
    store_data = 32'h0;
    rd_in      = 4'h0;
    link_in    = 1'b0;
    wb_en_in   = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_dmem_req", 32'(dmem_req), 32'd0);
    check("reset_stall_out", 32'(stall_out), 32'd0);
    check("reset_wb_en_out", 32'(wb_en_out), 32'd0);
    check("reset_fault_out", 32'(fault_out), 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    mon_en  = 1'b1;
    resp_en = 1'b1;

    // ADD, LDR with ack on second REQ cycle, LDRB, STRB
    issue(1, 0, 0, 0, 32'h0000_1234, 32'h0, 4'd3, 0, 1, 32'h0, 0, 0);
    issue(1, 1, 0, 0, 32'h0000_0100, 32'h0, 4'd5, 1, 1, 32'hDEAD_BEEF, 1, 0);
    issue(1, 1, 0, 1, 32'h0000_0103, 32'h0, 4'd6, 0, 1, 32'hAABB_CCDD, 0, 0);
    issue(1, 0, 1, 1, 32'h0000_0202, 32'h0000_0055, 4'd0, 0, 0, 32'h0, 2, 0);

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 5);
      v    = (kind != 0);
      rd   = (kind == 3) || (kind == 5) || ((kind == 0) && 1'($urandom));
      wr   = (kind == 4);
      bop  = 1'($urandom);
      issue(v, rd, wr, bop, $urandom, $urandom, 4'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom_range(0, 3), 0);
    end

    // Reset during REQ, then an ack one cycle later that must be ignored
    mon_en   = 1'b0;
    resp_en  = 1'b0;
    dmem_ack = 1'b0;
    in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; byte_op = 1'b0;
    alu_result = 32'h0000_0300; rd_in = 4'd7; link_in = 1'b0; wb_en_in = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_pre_dmem_req", 32'(dmem_req), 32'd1);
    check("rst_pre_stall_out", 32'(stall_out), 32'd1);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_stall_out", 32'(stall_out), 32'd0);
    check("rst_wb_en_out", 32'(wb_en_out), 32'd0);
    check("rst_fault_out", 32'(fault_out), 32'd0);
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("rst_ack_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_ack_stall_out", 32'(stall_out), 32'd0);
    check("rst_ack_wb_en_out", 32'(wb_en_out), 32'd0);
    @(posedge clk);
    #1;
    mon_en  = 1'b1;
    resp_en = 1'b1;
    issue(1, 0, 0, 0, 32'h0000_5A5A, 32'h0, 4'd9, 1, 1, 32'h0, 0, 0);

`ifdef DMEM_TIMEOUT_EN
    resp_en  = 1'b0;
    dmem_ack = 1'b0;
    issue(1, 1, 0, 0, 32'h0000_0400, 32'h0, 4'd2, 0, 1, 32'h0, 0, 1);
    resp_en  = 1'b1;
    issue(1, 0, 0, 0, 32'h0000_0077, 32'h0, 4'd4, 0, 1, 32'h0, 0, 0);
`endif

    in_valid = 1'b0;
    mon_en   = 1'b0;
    repeat (2) @(posedge clk);
    check("out_q_drained", 32'(out_q.size()), 32'd0);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
